// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side adapter and its output buffer.
// Latency and backpressure are not applicable here: the package holds declarations only.
package fifo_pkg;

    localparam int ADAPT_BUF_DEPTH = 2;
    localparam int ADAPT_CNT_W     = $clog2(ADAPT_BUF_DEPTH + 1);
    localparam int ADAPT_IDX_W     = $clog2(ADAPT_BUF_DEPTH);

    typedef logic [ADAPT_CNT_W-1:0] cnt_t;
    typedef logic [ADAPT_IDX_W-1:0] idx_t;
    // One extra bit so that cnt + push can be formed without wrapping.
    typedef logic [ADAPT_CNT_W:0]   cnt_ext_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry indexed output buffer; a push is visible at head_o on the next cycle.
// No internal backpressure: the caller guarantees it never pushes into a full buffer without popping.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output cnt_t                  cnt_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] slot_q [ADAPT_BUF_DEPTH];
    idx_t                  wr_idx_q;
    idx_t                  rd_idx_q;
    cnt_t                  cnt_q;
    cnt_t                  cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_idx_q <= ~wr_idx_q;
            end
            if (pop_i) begin
                rd_idx_q <= ~rd_idx_q;
            end
            cnt_q <= cnt_d;
        end
    end

    // Payload storage is deliberately not reset; occupancy tracking alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            slot_q[wr_idx_q] <= push_dat_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = slot_q[rd_idx_q];

    a_no_drop : assert property (@(posedge clk) disable iff (!rst_n)
        !((cnt_q == cnt_t'(ADAPT_BUF_DEPTH)) && push_i && !pop_i));

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !((cnt_q == '0) && pop_i));

endmodule

// File: rtl/sync_fifo_rd_adapter.sv
// Turns the FIFO pop interface into a valid/ready stream via a 2-entry prefetch buffer.
// Latency: read enable in N, data in N+1, m_valid in N+2; reads stop when pending data would overfill the buffer.
module sync_fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [ADAPT_CNT_W-1:0] buf_cnt
);

    logic     pend_q;
    logic     pend_d;
    logic     push;
    logic     pop;
    cnt_t     cnt;
    cnt_ext_t cnt_next;

    assign pop  = m_valid && m_ready;
    assign push = pend_q;

    // pop implies cnt >= 1, so the subtraction never wraps.
    assign cnt_next = cnt_ext_t'(cnt) + cnt_ext_t'(push) - cnt_ext_t'(pop);

    // A read issued now lands next cycle; only issue it when that word is sure to have a slot.
    assign fifo_rd_en = !fifo_empty && (cnt_next < cnt_ext_t'(ADAPT_BUF_DEPTH));
    assign pend_d     = fifo_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (fifo_data),
        .pop_i      (pop),
        .cnt_o      (cnt),
        .head_o     (m_data)
    );

    assign m_valid = (cnt != '0);
    assign buf_cnt = cnt;

    a_rd_not_empty : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_sync_fifo_rd_adapter.sv
// Directed bench for sync_fifo_rd_adapter: a behavioural FIFO feeds the DUT, a vector table plus
// hand-written sequences cover latency, backpressure, drain/refill and asynchronous reset.
module tb_sync_fifo_rd_adapter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] buf_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo_rd_adapter #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_cnt    (buf_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural source FIFO: registered read data, combinational empty, flushed by rst_n.
    logic [7:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic fifo_push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] wdat;
        bit         rdy;
        bit         e_rd;
        bit         e_vld;
        logic [1:0] e_cnt;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vec [13];

    initial begin
        logic [7:0] got [$];
        int first_rd;
        int first_vld;
        int n_rd;
        int maxc;

        // Single word with read latency, then a 3-word burst under backpressure and its release.
        vec[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        vec[1]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
        vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h5A};
        vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        vec[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vec[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vec[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'd1, 8'h11};
        vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 8'h11};
        vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h11};
        vec[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h22};
        vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h33};
        vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

        // Reset, then idle with the FIFO empty.
        repeat (3) step();
        @(negedge clk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_buf_cnt", int'(buf_cnt), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_m_valid", int'(m_valid), 0);
            chk("idle_buf_cnt", int'(buf_cnt), 0);
            chk("idle_rd_en", int'(fifo_rd_en), 0);
            step();
        end

        // Vector table.
        for (int v = 0; v < 13; v++) begin
            if (vec[v].wr) fifo_push(vec[v].wdat);
            m_ready = vec[v].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", v), int'(fifo_rd_en), int'(vec[v].e_rd));
            chk($sformatf("vec%0d_m_valid", v), int'(m_valid), int'(vec[v].e_vld));
            chk($sformatf("vec%0d_buf_cnt", v), int'(buf_cnt), int'(vec[v].e_cnt));
            if (vec[v].e_vld) chk($sformatf("vec%0d_m_data", v), int'(m_data), int'(vec[v].e_dat));
            step();
        end

        // Second single word after 10 idle cycles: visible two cycles after empty falls.
        repeat (10) step();
        fifo_push(8'h77);
        @(negedge clk);
        chk("late_rd_en", int'(fifo_rd_en), 1);
        chk("late_vld_n0", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("late_vld_n1", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("late_vld_n2", int'(m_valid), 1);
        chk("late_data", int'(m_data), 'h77);
        step();
        @(negedge clk);
        chk("late_drained", int'(m_valid), 0);
        step();

        // 16-word stream with m_ready high: latency 2, then back-to-back beats.
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) fifo_push(8'(i));
        first_rd = -1;
        first_vld = -1;
        for (int k = 0; k < 20 && first_vld < 0; k++) begin
            @(negedge clk);
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (m_valid) first_vld = k;
        end
        chk("stream_first_vld_seen", int'(first_vld >= 0), 1);
        if (first_vld >= 0) begin
            chk("stream_latency", first_vld - first_rd, 2);
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("stream_vld%0d", i), int'(m_valid), 1);
                chk($sformatf("stream_dat%0d", i), int'(m_data), i + 1);
                @(negedge clk);
            end
            chk("stream_end_vld", int'(m_valid), 0);
        end
        step();

        // Backpressure: exactly two reads, head held, then release without bubbles.
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_push(8'(i));
        n_rd = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (fifo_rd_en) n_rd++;
            if (i >= 4) chk("bp_head_stable", int'(m_data), 'h01);
        end
        chk("bp_reads", n_rd, 2);
        chk("bp_buf_cnt", int'(buf_cnt), 2);
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("bp_vld%0d", i), int'(m_valid), 1);
            chk($sformatf("bp_dat%0d", i), int'(m_data), i + 1);
            step();
        end
        @(negedge clk);
        chk("bp_end_vld", int'(m_valid), 0);
        step();

        // m_ready toggling every cycle over 16 words.
        got.delete();
        maxc = 0;
        for (int i = 1; i <= 16; i++) fifo_push(8'(8'h40 + i));
        for (int c = 0; c < 200 && got.size() < 16; c++) begin
            if (c > 0) step();
            m_ready = (c % 2 == 0);
            @(negedge clk);
            if (int'(buf_cnt) > maxc) maxc = int'(buf_cnt);
            if (m_valid && m_ready) got.push_back(m_data);
        end
        step();
        m_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("tog_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            chk($sformatf("tog_dat%0d", i), int'(got[i]), 'h40 + i + 1);
        end
        chk("tog_max_cnt_le2", int'(maxc <= 2), 1);
        chk("tog_drained", int'(m_valid), 0);
        step();

        // Asynchronous reset with a full buffer, then a clean restart.
        m_ready = 1'b0;
        fifo_push(8'hB1);
        fifo_push(8'hB2);
        fifo_push(8'hB3);
        repeat (4) step();
        @(negedge clk);
        chk("rst_pre_cnt", int'(buf_cnt), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_buf_cnt", int'(buf_cnt), 0);
        chk("arst_rd_en", int'(fifo_rd_en), 0);
        step();
        step();
        rst_n = 1'b1;
        m_ready = 1'b1;
        fifo_push(8'hA1);
        fifo_push(8'hA2);
        @(negedge clk);
        chk("restart_rd_en", int'(fifo_rd_en), 1);
        chk("restart_vld_n0", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("restart_vld_n1", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("restart_vld_a1", int'(m_valid), 1);
        chk("restart_dat_a1", int'(m_data), 'hA1);
        step();
        @(negedge clk);
        chk("restart_vld_a2", int'(m_valid), 1);
        chk("restart_dat_a2", int'(m_data), 'hA2);
        step();
        @(negedge clk);
        chk("restart_end_vld", int'(m_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
